// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART tx line between NUM_REQ requesters.
// Optional even parity bit after the data bits when UART_PARITY_EN is defined.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx,
    output logic                      busy,
    output logic [ID_W-1:0]           cur_id,
    output logic                      done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned SC_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]    r_bit_cnt, w_bit_nxt;
    logic [SC_W-1:0]     r_stop_cnt, w_stop_nxt;
    logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
    logic                r_tx, w_tx_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [ID_W-1:0]     r_cur_id, w_id_nxt;
`ifdef UART_PARITY_EN
    logic                r_par, w_par_nxt;
`endif

    logic                w_found;
    logic [ID_W-1:0]     w_win;
    logic [DATA_W-1:0]   w_win_data;

    // Round-robin pick: first pending request at or after r_rr_ptr, wrapping
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_bit_nxt   = r_bit_cnt;
        w_stop_nxt  = r_stop_cnt;
        w_shreg_nxt = r_shreg;
        w_tx_nxt    = r_tx;
        w_gnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_id_nxt    = r_cur_id;
`ifdef UART_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_found) begin
                    w_gnt_nxt   = NUM_REQ'(1) << w_win;
                    w_shreg_nxt = w_win_data;
                    w_id_nxt    = w_win;
                    w_rr_nxt    = ID_W'((32'(w_win) + 32'd1) % NUM_REQ);
                    w_state_nxt = S_LOAD;
`ifdef UART_PARITY_EN
                    w_par_nxt   = ^w_win_data;
`endif
                end
            end
            // A tick in the grant cycle itself (r_gnt still high) is ignored
            S_LOAD: begin
                if (tx_en && (r_gnt == '0)) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (tx_en) begin
                    w_tx_nxt    = r_shreg[0];
                    w_shreg_nxt = r_shreg >> 1;
                    w_bit_nxt   = CNT_W'(1);
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_en) begin
                    if (r_bit_cnt == CNT_W'(DATA_W)) begin
`ifdef UART_PARITY_EN
                        w_tx_nxt    = r_par;
                        w_state_nxt = S_PARITY;
`else
                        w_tx_nxt    = 1'b1;
                        w_stop_nxt  = SC_W'(1);
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_tx_nxt    = r_shreg[0];
                        w_shreg_nxt = r_shreg >> 1;
                        w_bit_nxt   = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (tx_en) begin
                    w_tx_nxt    = 1'b1;
                    w_stop_nxt  = SC_W'(1);
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (tx_en) begin
                    if (r_stop_cnt == SC_W'(STOP_BITS)) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_nxt = r_stop_cnt + SC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cur_id   <= '0;
`ifdef UART_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_shreg    <= w_shreg_nxt;
            r_tx       <= w_tx_nxt;
            r_gnt      <= w_gnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_cur_id   <= w_id_nxt;
`ifdef UART_PARITY_EN
            r_par      <= w_par_nxt;
`endif
        end
    end

    assign gnt    = r_gnt;
    assign tx     = r_tx;
    assign busy   = r_busy;
    assign cur_id = r_cur_id;
    assign done   = r_done;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART serial transmit line between NUM_REQ requesters. It arbitrates among pending byte requests and latches the winner's data. It then sequences start, data, optional parity and stop bits, advancing one bit per tx_en tick from the baud rate generator. It sits between the requesting client blocks and the tx pin, downstream of baud_rate.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data bits per frame, sent LSB first
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_en  input  1  baud tick, one clk-wide pulse per bit period, from baud_rate
req  input  NUM_REQ  per-requester request; held high with data stable until gnt is seen
req_data  input  NUM_REQ*DATA_W  packed data; requester i owns bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot, one-cycle pulse: data of that requester latched
tx  output  1  serial line, idle high
busy  output  1  high whenever state != IDLE
cur_id  output  $clog2(NUM_REQ)  index of requester owning the current or last frame
done  output  1  one-cycle pulse when a frame's final stop bit period ends

Behaviour:
- Reset (async, rst_n=0) values:
  - State machine: state=IDLE.
  - Outputs: tx=1, gnt=0, busy=0, done=0, cur_id=0.
  - Internal: rr_ptr=0, bit_cnt=0, stop_cnt=0, shift register=0.
- States: IDLE, LOAD, START, DATA, [PARITY], STOP. All outputs are registered.
- IDLE, tx=1:
  - If req!=0, arbitrate, ignoring tx_en. The winner is the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Next cycle: gnt[winner]=1 for exactly one cycle; shreg=req_data[winner]; cur_id=winner; rr_ptr=(winner+1) mod NUM_REQ; state=LOAD.
- LOAD: waits for a tx_en that occurs after the grant cycle. On that tx_en: tx=0 (start bit), state=START.
- START: on tx_en:
  - tx=shreg[0]; shreg shifts right.
  - bit_cnt=1; state=DATA.
- DATA: on tx_en:
  - If bit_cnt==DATA_W, end of data: go to STOP with tx=1 and stop_cnt=1, or to PARITY when the macro is defined.
  - Otherwise: tx=shreg[0], shift, bit_cnt+1.
- STOP: on tx_en:
  - If stop_cnt==STOP_BITS: state=IDLE, done=1 for one cycle.
  - Otherwise: stop_cnt+1.
  - tx stays 1 throughout.
- Frame timing: each bit is held for exactly one tick interval. Frame length is 1+DATA_W+STOP_BITS tick intervals, measured from the tick that exits LOAD.
- Boundary conditions:
  - Back-to-back frames: arbitration restarts in IDLE the cycle after done, so there is a minimum of one idle cycle on the fabric side. The line shows no gap beyond the LOAD wait for the next tick.
  - req deasserting in LOAD or later has no effect; the data is already latched.
  - req deasserting before gnt is issued: the request is dropped, with no glitch grant.
  - tx_en asserted outside the frame states (IDLE, or the grant cycle itself) has no effect.
  - Reset mid-frame: tx returns to 1 immediately, the frame is abandoned, no done pulse is issued, and rr_ptr returns to 0.
  - A single requester asserting continuously is granted on every frame.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: PARITY state inserted after DATA.
  - On the DATA-exit tick, tx = XOR of the latched data (even parity); state=PARITY.
  - The next tick leads to STOP with tx=1.
  - Frame length becomes 2+DATA_W+STOP_BITS ticks.
- Undefined: no PARITY state; DATA goes directly to STOP; no parity logic is synthesized.

Test Plan:
- Single request: req=4'b0010, req_data[15:8]=8'hA5, tx_en every 4 clks -> gnt=4'b0010 for one cycle, cur_id=1. tx per tick = 0,1,0,1,0,0,1,0,1,1, then done pulses and busy falls.
- Contention after reset: req=4'b1111 held, re-raised after each gnt -> grant order 0,1,2,3,0.
- Fairness: req0 and req2 held continuously -> grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
- Tick coincident with the grant cycle -> ignored; tx stays 1 until the next tick, which drives the start bit 0.
- rst_n low during the 3rd data bit -> same cycle: tx=1, busy=0, gnt=0. After release, req=4'b1000 is granted per pointer 0 scan and then transmits normally.
- Parity: with UART_PARITY_EN, data 8'h07 -> 11-bit frame with parity bit 1. Without the macro -> 10-bit frame, no parity bit.
